hbm_pc_rd_arbiter: RTL and testbench

// - Shares one HBM pseudo-channel AXI4 read port between NB_REQ read requesters,
//   e.g. BSK/KSK/PEM/GLWE readers mapped onto the same PC.
// - Fair round-robin on AR; caps outstanding bursts per requester.
// - Tags ARID with the requester index and steers R beats back by RID.
// - One instance per pseudo-channel. The top instantiates BSK_PC, KSK_PC, PEM_PC and GLWE_PC copies.

---
 rtl/hbm_pc_rd_arbiter_pkg.sv | 24 ++
 rtl/hbm_pc_rd_arbiter_rr.sv | 42 ++++
 rtl/hbm_pc_rd_arbiter.sv | 122 ++++++++++++
 tb/tb_hbm_pc_rd_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hbm_pc_rd_arbiter_pkg.sv
// hbm_pc_rd_arbiter_pkg: shared types, error bit positions and sizing helper
// for the HBM pseudo-channel read arbiter.
package hbm_pc_rd_arbiter_pkg;

    // Command fields are sized for the widest supported port; narrower ports use the low bits.
    localparam int CMD_ADD_W = 64;
    localparam int CMD_LEN_W = 8;
    localparam int CMD_ID_W  = 4;

    localparam int ERR_RRESP = 0;
    localparam int ERR_RID   = 1;
    localparam int ERR_RLAST = 2;

    typedef struct packed {
        logic [CMD_ADD_W-1:0] addr;
        logic [CMD_LEN_W-1:0] len;
        logic [CMD_ID_W-1:0]  id;
    } ar_cmd_t;

    function automatic int req_idx_w(input int nb_req);
        return (nb_req > 1) ? $clog2(nb_req) : 1;
    endfunction

endpackage

// File: rtl/hbm_pc_rd_arbiter_rr.sv
// pc_rr_arbiter: round-robin pick of the first eligible requester at or after
// a registered pointer; the pointer advances past the winner on each grant.
module pc_rr_arbiter
    import hbm_pc_rd_arbiter_pkg::*;
#(
    parameter int NB_REQ = 2
) (
    input  logic              clk,
    input  logic              a_rst_n,
    input  logic [NB_REQ-1:0] eligible,
    input  logic              update,
    output logic [NB_REQ-1:0] grant
);

    localparam int PW = req_idx_w(NB_REQ);

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant   = '0;
        ptr_nxt = ptr;
        idx     = '0;
        found   = 1'b0;
        for (int k = 0; k < NB_REQ; k++) begin
            idx = PW'((int'(ptr) + k) % NB_REQ);
            if (!found && update && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                ptr_nxt    = PW'((int'(ptr) + k + 1) % NB_REQ);
            end
        end
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) ptr <= '0;
        else          ptr <= ptr_nxt;
    end

endmodule

// File: rtl/hbm_pc_rd_arbiter.sv
// hbm_pc_rd_arbiter: shares one HBM pseudo-channel AXI4 read port between NB_REQ
// requesters with round-robin AR, per-requester burst credits and RID steering.
module hbm_pc_rd_arbiter
    import hbm_pc_rd_arbiter_pkg::*;
#(
    parameter int NB_REQ     = 2,
    parameter int AXI_ADD_W  = 64,
    parameter int AXI_DATA_W = 512,
    parameter int AXI_ID_W   = 4,
    parameter int AXI_LEN_W  = 8,
    parameter int MAX_OUTSTD = 16
) (
    input  logic                        clk,
    input  logic                        a_rst_n,
    input  logic [NB_REQ-1:0]           req_arvalid,
    output logic [NB_REQ-1:0]           req_arready,
    input  logic [NB_REQ*AXI_ADD_W-1:0] req_araddr,
    input  logic [NB_REQ*AXI_LEN_W-1:0] req_arlen,
    output logic [AXI_ID_W-1:0]         m_axi_arid,
    output logic [AXI_ADD_W-1:0]        m_axi_araddr,
    output logic [AXI_LEN_W-1:0]        m_axi_arlen,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    input  logic [AXI_ID_W-1:0]         m_axi_rid,
    input  logic [AXI_DATA_W-1:0]       m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rlast,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready,
    output logic [NB_REQ-1:0]           req_rvalid,
    output logic [AXI_DATA_W-1:0]       req_rdata,
    output logic                        req_rlast,
    input  logic [NB_REQ-1:0]           req_rready,
    output logic                        idle,
    output logic [2:0]                  error
);

    localparam int CW = $clog2(MAX_OUTSTD + 1);

    ar_cmd_t           cmd_q, cmd_d;
    logic              arvalid_q;
    logic              slot_free;
    logic [NB_REQ-1:0] eligible, grant, dec;
    logic [CW-1:0]     outstd [NB_REQ];
    logic              rid_ok, rlast_hs, underflow;
    logic [2:0]        err_q, err_set;

    pc_rr_arbiter #(.NB_REQ(NB_REQ)) u_rr (
        .clk      (clk),
        .a_rst_n  (a_rst_n),
        .eligible (eligible),
        .update   (slot_free),
        .grant    (grant)
    );

    assign slot_free     = !arvalid_q || m_axi_arready;
    assign req_arready   = grant;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_arid    = AXI_ID_W'(cmd_q.id);
    assign m_axi_araddr  = AXI_ADD_W'(cmd_q.addr);
    assign m_axi_arlen   = AXI_LEN_W'(cmd_q.len);
    assign req_rdata     = m_axi_rdata;
    assign req_rlast     = m_axi_rlast;
    assign error         = err_q;

    always_comb begin
        cmd_d        = cmd_q;
        eligible     = '0;
        req_rvalid   = '0;
        dec          = '0;
        m_axi_rready = 1'b1;
        rid_ok       = 1'b0;
        underflow    = 1'b0;
        idle         = !arvalid_q;
        for (int i = 0; i < NB_REQ; i++) begin
            eligible[i] = req_arvalid[i] && (outstd[i] < CW'(MAX_OUTSTD));
            idle        = idle && (outstd[i] == '0);
            if (grant[i]) begin
                cmd_d.addr = CMD_ADD_W'(req_araddr[i*AXI_ADD_W +: AXI_ADD_W]);
                cmd_d.len  = CMD_LEN_W'(req_arlen[i*AXI_LEN_W +: AXI_LEN_W]);
                cmd_d.id   = CMD_ID_W'(i);
            end
            if (m_axi_rid == AXI_ID_W'(i)) begin
                rid_ok        = 1'b1;
                m_axi_rready  = req_rready[i];
                req_rvalid[i] = m_axi_rvalid;
            end
        end
        // Unknown RIDs fall through with rready=1 so the channel never stalls on them.
        rlast_hs = m_axi_rvalid && m_axi_rready && m_axi_rlast;
        for (int i = 0; i < NB_REQ; i++) begin
            if (rlast_hs && m_axi_rid == AXI_ID_W'(i)) begin
                dec[i]    = outstd[i] != '0;
                underflow = outstd[i] == '0;
            end
        end
        err_set            = '0;
        err_set[ERR_RRESP] = m_axi_rvalid && m_axi_rready && (m_axi_rresp != 2'b00);
        err_set[ERR_RID]   = m_axi_rvalid && !rid_ok;
        err_set[ERR_RLAST] = underflow;
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            cmd_q     <= '0;
            arvalid_q <= 1'b0;
            err_q     <= '0;
            for (int i = 0; i < NB_REQ; i++) outstd[i] <= '0;
        end else begin
            cmd_q     <= cmd_d;
            arvalid_q <= (|grant) || (arvalid_q && !m_axi_arready);
            err_q     <= err_q | err_set;
            for (int i = 0; i < NB_REQ; i++) begin
                if (grant[i] && !dec[i] && outstd[i] != CW'(MAX_OUTSTD))
                    outstd[i] <= outstd[i] + 1'b1;
                else if (dec[i] && !grant[i])
                    outstd[i] <= outstd[i] - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hbm_pc_rd_arbiter.sv
// tb_hbm_pc_rd_arbiter: directed bench with AR/R scoreboards; a second instance
// with a credit limit of 2 covers the outstanding-burst cap.
module tb_hbm_pc_rd_arbiter;

    localparam int N = 2, AW = 64, DW = 512, IW = 4, LW = 8;

    logic            clk = 1'b0, a_rst_n = 1'b0;
    logic [N-1:0]    req_arvalid = '0, req_rready = '1;
    logic [N*AW-1:0] req_araddr = '0;
    logic [N*LW-1:0] req_arlen = '0;
    logic            arready = 1'b0, rvalid = 1'b0, rlast = 1'b0;
    logic [IW-1:0]   rid = '0;
    logic [DW-1:0]   rdata = '0;
    logic [1:0]      rresp = '0;

    logic [N-1:0]  a_arready, a_rvalid, b_arready, b_rvalid;
    logic [IW-1:0] a_arid, b_arid;
    logic [AW-1:0] a_araddr, b_araddr;
    logic [LW-1:0] a_arlen, b_arlen;
    logic          a_arvalid, b_arvalid, a_rready, b_rready, a_rlast, b_rlast, a_idle, b_idle;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [2:0]    a_err, b_err;

    int   total = 0, bad = 0;
    logic mon_en = 1'b1;
    logic [IW+AW+LW-1:0] exp_ar[$];
    logic [N+DW:0]       exp_r[$];

    always #5 clk = ~clk;

    hbm_pc_rd_arbiter #(.NB_REQ(N), .MAX_OUTSTD(16)) dut_a (
        .clk(clk), .a_rst_n(a_rst_n), .req_arvalid(req_arvalid), .req_arready(a_arready),
        .req_araddr(req_araddr), .req_arlen(req_arlen), .m_axi_arid(a_arid),
        .m_axi_araddr(a_araddr), .m_axi_arlen(a_arlen), .m_axi_arvalid(a_arvalid),
        .m_axi_arready(arready), .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(a_rready),
        .req_rvalid(a_rvalid), .req_rdata(a_rdata), .req_rlast(a_rlast),
        .req_rready(req_rready), .idle(a_idle), .error(a_err)
    );

    hbm_pc_rd_arbiter #(.NB_REQ(N), .MAX_OUTSTD(2)) dut_b (
        .clk(clk), .a_rst_n(a_rst_n), .req_arvalid(req_arvalid), .req_arready(b_arready),
        .req_araddr(req_araddr), .req_arlen(req_arlen), .m_axi_arid(b_arid),
        .m_axi_araddr(b_araddr), .m_axi_arlen(b_arlen), .m_axi_arvalid(b_arvalid),
        .m_axi_arready(arready), .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(b_rready),
        .req_rvalid(b_rvalid), .req_rdata(b_rdata), .req_rlast(b_rlast),
        .req_rready(req_rready), .idle(b_idle), .error(b_err)
    );

    task automatic check(input string tag, input logic [519:0] obs, input logic [519:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_rst_n = 1'b0;
        req_arvalid = '0;
        rvalid = 1'b0;
        rlast = 1'b0;
        rresp = '0;
        req_rready = '1;
        tick();
        tick();
        a_rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (a_rst_n && mon_en && a_arvalid && arready) begin
            check("ar_pending", exp_ar.size() != 0, 1);
            if (exp_ar.size() != 0) check("ar_fields", {a_arid, a_araddr, a_arlen}, exp_ar.pop_front());
        end
        if (a_rst_n && rvalid && a_rready) begin
            check("r_pending", exp_r.size() != 0, 1);
            if (exp_r.size() != 0) check("r_beat", {a_rvalid, a_rdata, a_rlast}, exp_r.pop_front());
        end
    end

    initial begin
        a_rst_n = 1'b0;
        tick();
        tick();
        check("rst_arvalid", a_arvalid, 0);
        check("rst_arready", a_arready, 0);
        check("rst_ar_fields", {a_arid, a_araddr, a_arlen}, 0);
        check("rst_idle", a_idle, 1);
        check("rst_error", a_err, 0);
        a_rst_n = 1'b1;

        // single requester, three back-to-back bursts
        arready = 1'b1;
        req_arvalid = 2'b01;
        for (int k = 0; k < 3; k++) begin
            req_araddr[AW-1:0] = AW'(k * 64);
            req_arlen[LW-1:0] = 8'd3;
            exp_ar.push_back({4'd0, AW'(k * 64), 8'd3});
            #1 check("t1_grant", a_arready, 2'b01);
            tick();
            check("t1_arvalid", a_arvalid, 1);
        end
        req_arvalid = '0;
        tick();
        check("t1_arvalid_drop", a_arvalid, 0);
        check("t1_busy", a_idle, 0);
        for (int b = 0; b < 12; b++) begin
            rvalid = 1'b1;
            rid = 4'd0;
            rdata = DW'(b + 100);
            rlast = (b % 4 == 3);
            exp_r.push_back({2'b01, rdata, rlast});
            tick();
        end
        rvalid = 1'b0;
        rlast = 1'b0;
        #1 check("t1_idle", a_idle, 1);

        // fairness with both requesters always valid
        do_reset();
        req_araddr = {64'h2000, 64'h1000};
        req_arlen = {8'd2, 8'd1};
        req_arvalid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_ar.push_back((k % 2) != 0 ? {4'd1, 64'h2000, 8'd2} : {4'd0, 64'h1000, 8'd1});
            #1 check("t2_rr_grant", a_arready, (k % 2) != 0 ? 2'b10 : 2'b01);
            tick();
        end
        req_arvalid = '0;
        tick();
        tick();

        // AR backpressure
        do_reset();
        arready = 1'b0;
        req_arvalid = 2'b01;
        req_araddr[AW-1:0] = 64'h3000;
        req_arlen[LW-1:0] = 8'd5;
        exp_ar.push_back({4'd0, 64'h3000, 8'd5});
        #1 check("t3_grant", a_arready, 2'b01);
        tick();
        req_araddr[AW-1:0] = 64'h4000;
        for (int k = 0; k < 5; k++) begin
            #1 check("t3_no_pulse", a_arready, 0);
            check("t3_stable", {a_arvalid, a_araddr}, {1'b1, 64'h3000});
            tick();
        end
        arready = 1'b1;
        exp_ar.push_back({4'd0, 64'h4000, 8'd5});
        #1 check("t3_resume", a_arready, 2'b01);
        tick();
        req_arvalid = '0;
        tick();
        #1 check("t3_drained", a_arvalid, 0);

        // credit cap on the MAX_OUTSTD=2 instance
        do_reset();
        mon_en = 1'b0;
        req_arvalid = 2'b01;
        for (int k = 0; k < 3; k++) begin
            #1 check("t4_req0", b_arready, k < 2 ? 2'b01 : 2'b00);
            tick();
        end
        req_arvalid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            #1 check("t4_req1", b_arready, k < 2 ? 2'b10 : 2'b00);
            tick();
        end
        req_arvalid = 2'b01;
        rvalid = 1'b1;
        rid = 4'd0;
        rlast = 1'b1;
        rdata = DW'(32'hC0DE);
        exp_r.push_back({2'b01, rdata, 1'b1});
        #1 check("t4_still_capped", b_arready, 0);
        tick();
        rvalid = 1'b0;
        #1 check("t4_credit_back", b_arready, 2'b01);
        tick();
        req_arvalid = '0;
        tick();

        // simultaneous grant and rlast for req1
        do_reset();
        mon_en = 1'b0;
        req_arvalid = 2'b10;
        #1 check("t5_first", b_arready, 2'b10);
        tick();
        rvalid = 1'b1;
        rid = 4'd1;
        rlast = 1'b1;
        rdata = DW'(32'hBEEF);
        exp_r.push_back({2'b10, rdata, 1'b1});
        #1 check("t5_same_cycle", b_arready, 2'b10);
        tick();
        rvalid = 1'b0;
        #1 check("t5_one_left", b_arready, 2'b10);
        tick();
        #1 check("t5_capped", b_arready, 0);
        req_arvalid = '0;
        for (int k = 0; k < 2; k++) begin
            rvalid = 1'b1;
            exp_r.push_back({2'b10, rdata, 1'b1});
            tick();
        end
        rvalid = 1'b0;
        #1 check("t5_idle", {b_idle, b_err}, {1'b1, 3'b000});

        // sticky errors
        do_reset();
        mon_en = 1'b1;
        req_rready = 2'b00;
        rvalid = 1'b1;
        rid = 4'd3;
        rlast = 1'b0;
        rdata = DW'(32'hDEAD);
        exp_r.push_back({2'b00, rdata, 1'b0});
        #1 check("t6_drop_rready", a_rready, 1);
        check("t6_drop_rvalid", a_rvalid, 0);
        tick();
        rvalid = 1'b0;
        #1 check("t6_err_rid", a_err, 3'b010);
        req_rready = 2'b11;
        rvalid = 1'b1;
        rid = 4'd0;
        rresp = 2'd2;
        exp_r.push_back({2'b01, rdata, 1'b0});
        tick();
        rvalid = 1'b0;
        rresp = '0;
        #1 check("t6_err_rresp", a_err, 3'b011);
        rvalid = 1'b1;
        rlast = 1'b1;
        exp_r.push_back({2'b01, rdata, 1'b1});
        tick();
        rvalid = 1'b0;
        rlast = 1'b0;
        #1 check("t6_err_rlast", a_err, 3'b111);
        check("t6_counter_zero", a_idle, 1);
        req_rready = 2'b10;
        rvalid = 1'b1;
        #1 check("t6_rready_steer", {a_rready, a_rvalid}, {1'b0, 2'b01});
        tick();
        rvalid = 1'b0;
        do_reset();
        #1 check("t6_err_reset", a_err, 0);

        check("ar_sb_empty", exp_ar.size(), 0);
        check("r_sb_empty", exp_r.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
